// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: FSM state encoding and defaults.
package pipe_ctrl_pkg;

  // Memory-wait FSM states; the encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    ERR   = 2'd3
  } state_e;

  // Default number of cycles a memory request may wait for its acknowledge.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Default width of the performance counters.
  localparam int unsigned CNT_W_DEFAULT = 32;

endpackage

// File: rtl/perf_cnt.sv
// Free-running event counter: counts cycles with inc=1, wraps modulo 2^W.
module perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Count register; wraps naturally on overflow.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + {{(W-1){1'b0}}, inc};
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / memory-wait controller with timeout detection and
// performance counters. stall, jb and waiting are combinational.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_load_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             use_rs1_D,
  input  logic             use_rs2_D,
  input  logic             jb_taken_E,
  input  logic             imem_req,
  input  logic             imem_ack,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall,
  output logic             jb,
  output logic             waiting,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  // Timer holds 0..TIMEOUT-1; one extra bit on the increment catches the limit.
  localparam int unsigned   TMR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W:0] TO_LIM = (TMR_W + 1)'(TIMEOUT);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W:0]   timer_inc;
  logic             timeout_err_q;
  logic             hazard;
  logic             d_stall, i_stall;
  logic             wait_raw;

  // Load-use hazard: the loaded register is read by the instruction in D.
  assign hazard = is_load_E && (rd_E != 5'd0) &&
                  ((use_rs1_D && (rs1_D == rd_E)) || (use_rs2_D && (rs2_D == rd_E)));

  assign d_stall   = dmem_req && !dmem_ack;
  assign i_stall   = imem_req && !imem_ack;
  assign timer_inc = {1'b0, timer_q} + {{TMR_W{1'b0}}, 1'b1};

  // Next-state, wait timer and raw waiting request.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    wait_raw = 1'b0;
    unique case (state_q)
      RUN: begin
        if (d_stall) begin
          wait_raw = 1'b1;
          state_d  = DWAIT;
        end else if (i_stall) begin
          wait_raw = 1'b1;
          state_d  = IWAIT;
        end
      end
      DWAIT: begin
        if (dmem_ack) state_d  = RUN;
        else          wait_raw = 1'b1;
      end
      IWAIT: begin
        if (imem_ack) state_d  = RUN;
        else          wait_raw = 1'b1;
      end
      ERR: ;  // pipeline keeps running; only reset leaves ERR
      default: state_d = RUN;
    endcase
    // Each waiting cycle advances the timer; hitting the limit abandons the wait.
    if (wait_raw) begin
      if (timer_inc >= TO_LIM) state_d = ERR;
      else                     timer_d = timer_inc[TMR_W-1:0];
    end
  end

  // FSM state, wait timer and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_q || (state_d == ERR);
    end
  end

  // Priority waiting > jb > stall; everything forced low while in reset.
  assign waiting     = rst_n && wait_raw;
  assign jb          = rst_n && !wait_raw && jb_taken_E;
  assign stall       = rst_n && !wait_raw && !jb_taken_E && hazard;
  assign timeout_err = timeout_err_q;

  perf_cnt #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall),   .cnt(stall_cnt));
  perf_cnt #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(jb),      .cnt(flush_cnt));
  perf_cnt #(.W(CNT_W)) u_wait_cnt  (.clk(clk), .rst_n(rst_n), .inc(waiting), .cnt(wait_cnt));

endmodule
